tmds_word_aligner: RTL
======================

Name: tmds_word_aligner

Overview:
- Receive-side counterpart of the TMDS 10:1 transmit serializer.
- Takes free-running 10-bit raw words per channel from a 1:10 deserializer. Each raw word has an arbitrary bit phase.
- Finds the symbol boundary by hunting for runs of TMDS control tokens. Outputs word-aligned 10-bit symbols and per-channel lock status to the TMDS decoder.
- Sits between the deserializer primitives and the TMDS decoder, entirely in the clk_pixel domain.

Parameters:
- NUM_CHANNELS, 3, number of TMDS data channels aligned independently.
- CTRL_RUN, 8, consecutive control tokens required to declare lock (range 2..255).
- DWELL_CYCLES, 4096, clk_pixel cycles spent at one bit offset before advancing (range 16..65535).
- LOCK_TIMEOUT, 8192, cycles with no control token at the locked offset before lock is dropped (range 16..65535).

Ports:
- clk_pixel  input  1  pixel clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset. Asserts asynchronously; deassertion is synchronous to clk_pixel.
- tmds_raw  input  [9:0] x NUM_CHANNELS  raw deserialized word per channel, new value every cycle. Bit 0 is the earliest received bit.
- tmds_aligned  output  [9:0] x NUM_CHANNELS  aligned symbol per channel. Bit 0 is the first serialized bit.
- ctrl_token  output  NUM_CHANNELS  tmds_aligned[i] is one of the four control tokens this cycle.
- locked  output  NUM_CHANNELS  channel i is in LOCKED.
- all_locked  output  1  AND of all locked bits, registered.
- bit_offset  output  [3:0] x NUM_CHANNELS  current window offset, 0..9.

Behaviour:
- Window construction:
  - Per channel, register prev[i] <= tmds_raw[i].
  - Form cat = {tmds_raw[i], prev[i]} (20 bits).
  - Candidate = cat[bit_offset +: 10].
  - tmds_aligned and ctrl_token are registered from the candidate.
  - Latency: 1 cycle from tmds_raw to tmds_aligned.
- Control tokens, bit 9..0: 1101010100, 0010101011, 0101010100, 1010101011. Any other value is a non-token.
- Per-channel FSM states: SEARCH, VERIFY, LOCKED.
- Counters: dwell (16 b), run (8 b), gap (16 b).
- SEARCH:
  - dwell increments each cycle.
  - Token seen -> VERIFY, run=1.
  - dwell reaches DWELL_CYCLES-1 with no token -> bit_offset = (bit_offset==9) ? 0 : bit_offset+1; dwell=0; stay in SEARCH.
- VERIFY:
  - dwell keeps incrementing.
  - Token -> run+1.
  - run reaches CTRL_RUN -> LOCKED, gap=0.
  - Non-token -> SEARCH; offset unchanged; dwell not cleared.
  - Dwell expiry -> advance offset, SEARCH, run=0.
  - Dwell expiry on the same cycle run reaches CTRL_RUN -> lock wins; offset unchanged.
- LOCKED:
  - locked=1; bit_offset frozen.
  - gap clears on each token and otherwise increments.
  - gap reaches LOCK_TIMEOUT-1 -> SEARCH, offset unchanged, dwell=0, run=0.
  - locked deasserts on the cycle after the transition.
- Channels are fully independent; there is no inter-channel deskew.
- all_locked rises 1 cycle after the last locked bit rises and falls 1 cycle after any locked bit falls.
- Reset values: state SEARCH, bit_offset 0, counters 0, prev 0, tmds_aligned 0, ctrl_token 0, locked 0, all_locked 0.
- Reset mid-lock returns immediately to these values; the hunt restarts from offset 0.
- Counter widths: all counters are sized so they never wrap before their compare value.

Optional Feature:
- Macro: TMDS_WORD_ALIGNER_LOSS_COUNT_EN.
- Defined:
  - Adds output lock_loss_count, [15:0] x NUM_CHANNELS.
  - It is a saturating count of LOCKED->SEARCH transitions, saturating at 65535, reset to 0.
  - Adds input clear_loss_count, 1 bit; a synchronous clear of all counts.
  - Clear wins over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package tmds_pkg holds:
  - the four control-token localparams;
  - the aligner state enum (SEARCH/VERIFY/LOCKED);
  - the 10-bit symbol typedef.
- The serializer-side clock pattern constant also moves to tmds_pkg.
- Sub-module tmds_channel_aligner is instantiated NUM_CHANNELS times. It owns prev, the window mux, the FSM and the counters.
- The top level generates the channel instances plus all_locked.

Test Plan:
- Phase sweep: for each offset k = 0..9, build the raw stream by sending 0101010100 repeatedly, rotated by k bits (CTRL_RUN=8, DWELL_CYCLES=64).
  - Required: locked=1 within 64*10+10 cycles.
  - Required: bit_offset matches the expected value for k.
  - Required: tmds_aligned==0101010100 every cycle while locked.
- False start: 5 tokens, 1 non-token, then 8 tokens at the correct offset.
  - Required: no lock after the first 5; lock on the 8th token of the second burst.
  - Required: bit_offset unchanged throughout.
- Loss of lock: once locked, drive random non-token data for LOCK_TIMEOUT cycles.
  - Required: locked falls exactly LOCK_TIMEOUT+1 cycles after the last token.
  - Required: bit_offset is retained and the hunt resumes.
- Channel independence: channel 0 gets tokens at offset 3; channel 1 gets none; channel 2 gets tokens at offset 7.
  - Required: locked=3'b101, all_locked=0.
  - After channel 1 is fed tokens at offset 0, all_locked=1 one cycle after locked[1].
- Async reset while locked: pull reset low between clock edges.
  - Required: locked, all_locked, tmds_aligned and bit_offset go to 0 without waiting for a clk_pixel edge.
  - Required: relock proceeds normally after release.
- With TMDS_WORD_ALIGNER_LOSS_COUNT_EN: force 3 lock losses on channel 0.
  - Required: lock_loss_count[0]==3.
  - Asserting clear_loss_count on the same cycle as a 4th loss gives a count of 0.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol type, control tokens, aligner states and
// the serializer-side clock-channel pattern.
package tmds_pkg;

    // One 10-bit TMDS symbol, bit 0 is the first bit on the wire.
    typedef logic [9:0] tmds_symbol_t;

    // The four control tokens (C1,C0 = 00, 01, 10, 11), written bit 9..0.
    localparam tmds_symbol_t CTRL_TOKEN_00 = 10'b1101010100;
    localparam tmds_symbol_t CTRL_TOKEN_01 = 10'b0010101011;
    localparam tmds_symbol_t CTRL_TOKEN_10 = 10'b0101010100;
    localparam tmds_symbol_t CTRL_TOKEN_11 = 10'b1010101011;

    // Word the transmit serializer sends on the clock channel (5 low, 5 high).
    localparam tmds_symbol_t TMDS_CLK_PATTERN = 10'b0000011111;

    // Per-channel alignment state.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    // True when the symbol is one of the four control tokens.
    function automatic logic is_ctrl_token(input tmds_symbol_t sym);
        return (sym == CTRL_TOKEN_00) || (sym == CTRL_TOKEN_01) ||
               (sym == CTRL_TOKEN_10) || (sym == CTRL_TOKEN_11);
    endfunction

endpackage : tmds_pkg

// File: rtl/tmds_channel_aligner.sv
// Single-channel TMDS word aligner.
// Slides a 10-bit window over two consecutive raw words, hunts for a run of
// control tokens at each bit offset and locks onto the offset that yields one.
// Optional lock-loss counter: define TMDS_WORD_ALIGNER_LOSS_COUNT_EN.
module tmds_channel_aligner
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 8,
    parameter int DWELL_CYCLES = 4096,
    parameter int LOCK_TIMEOUT = 8192
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  tmds_symbol_t raw_i,
`ifdef TMDS_WORD_ALIGNER_LOSS_COUNT_EN
    input  logic         clear_loss_count_i,
    output logic [15:0]  lock_loss_count_o,
`endif
    output tmds_symbol_t aligned_o,
    output logic         ctrl_token_o,
    output logic         locked_o,
    output logic [3:0]   bit_offset_o
);

    // Compare values sized to the counters they are checked against.
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [7:0]  RUN_TARGET = 8'(CTRL_RUN);
    localparam logic [15:0] GAP_LAST   = 16'(LOCK_TIMEOUT - 1);

    // Datapath registers.
    tmds_symbol_t prev_q;
    tmds_symbol_t aligned_q;
    logic         ctrl_token_q;

    // FSM state and counters.
    align_state_e state_q, state_d;
    logic [3:0]   bit_offset_q, bit_offset_d;
    logic [15:0]  dwell_q, dwell_d;
    logic [7:0]   run_q, run_d;
    logic [15:0]  gap_q, gap_d;

    // Window signals.
    logic [19:0]  window_cat;
    tmds_symbol_t candidate;
    logic         token_c;

    // Helpers for the next-state logic.
    logic         dwell_expired;
    logic [3:0]   offset_next;
    logic [7:0]   run_inc;

    // Slide a 10-bit window across {current, previous} and classify it.
    always_comb begin
        window_cat = {raw_i, prev_q};
        candidate  = 10'(window_cat >> bit_offset_q);
        token_c    = is_ctrl_token(candidate);
    end

    // Capture the previous raw word and the registered aligned symbol.
    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            prev_q       <= '0;
            aligned_q    <= '0;
            ctrl_token_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            prev_q       <= raw_i;
            aligned_q    <= candidate;
            ctrl_token_q <= token_c;
        end
    end

    // FSM state register and counters.
    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            state_q      <= SEARCH;
            bit_offset_q <= '0;
            dwell_q      <= '0;
            run_q        <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            bit_offset_q <= bit_offset_d;
            dwell_q      <= dwell_d;
            run_q        <= run_d;
            gap_q        <= gap_d;
        end
    end

    // Next-state logic: hunt, verify a run of tokens, then hold lock.
    always_comb begin
        // NOTE: defaults first so every path assigns every _d signal; no latches.
        state_d      = state_q;
        bit_offset_d = bit_offset_q;
        dwell_d      = dwell_q;
        run_d        = run_q;
        gap_d        = gap_q;

        // A token seen on the last dwell cycle carries dwell one past the
        // limit into VERIFY, so expiry is a >= test.
        dwell_expired = (dwell_q >= DWELL_LAST);
        offset_next   = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
        run_inc       = run_q + 8'd1;

        unique case (state_q)
            SEARCH: begin
                if (token_c) begin
                    state_d = VERIFY;
                    run_d   = 8'd1;
                    dwell_d = dwell_q + 16'd1;
                end else if (dwell_expired) begin
                    bit_offset_d = offset_next;
                    dwell_d      = '0;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end

            VERIFY: begin
                dwell_d = dwell_q + 16'd1;
                if (token_c && (run_inc == RUN_TARGET)) begin
                    // Completing the run takes priority over a dwell expiry.
                    state_d = LOCKED;
                    run_d   = run_inc;
                    gap_d   = '0;
                end else if (dwell_expired) begin
                    state_d      = SEARCH;
                    bit_offset_d = offset_next;
                    dwell_d      = '0;
                    run_d        = '0;
                end else if (token_c) begin
                    run_d = run_inc;
                end else begin
                    // Broken run: retry this offset, dwell keeps counting.
                    state_d = SEARCH;
                    run_d   = '0;
                end
            end

            LOCKED: begin
                if (token_c) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = SEARCH;
                    dwell_d = '0;
                    run_d   = '0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        aligned_o    = aligned_q;
        ctrl_token_o = ctrl_token_q;
        locked_o     = (state_q == LOCKED);
        bit_offset_o = bit_offset_q;
    end

`ifdef TMDS_WORD_ALIGNER_LOSS_COUNT_EN
    logic [15:0] loss_count_q;
    logic        loss_event;

    assign loss_event        = (state_q == LOCKED) && (state_d == SEARCH);
    assign lock_loss_count_o = loss_count_q;

    // Saturating count of LOCKED->SEARCH drops; clear beats increment.
    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            loss_count_q <= '0;
        end else if (clear_loss_count_i) begin
            loss_count_q <= '0;
        end else if (loss_event && (loss_count_q != 16'hFFFF)) begin
            loss_count_q <= loss_count_q + 16'd1;
        end
    end
`endif

endmodule : tmds_channel_aligner

// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: one independent aligner per data channel plus
// a registered all-channels-locked flag. No inter-channel deskew.
// Optional lock-loss counters: define TMDS_WORD_ALIGNER_LOSS_COUNT_EN.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int CTRL_RUN     = 8,
    parameter int DWELL_CYCLES = 4096,
    parameter int LOCK_TIMEOUT = 8192
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    input  logic [NUM_CHANNELS-1:0][9:0]  tmds_raw,
`ifdef TMDS_WORD_ALIGNER_LOSS_COUNT_EN
    input  logic                          clear_loss_count,
    output logic [NUM_CHANNELS-1:0][15:0] lock_loss_count,
`endif
    output logic [NUM_CHANNELS-1:0][9:0]  tmds_aligned,
    output logic [NUM_CHANNELS-1:0]       ctrl_token,
    output logic [NUM_CHANNELS-1:0]       locked,
    output logic                          all_locked,
    output logic [NUM_CHANNELS-1:0][3:0]  bit_offset
);

    logic all_locked_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        tmds_channel_aligner #(
            .CTRL_RUN     (CTRL_RUN),
            .DWELL_CYCLES (DWELL_CYCLES),
            .LOCK_TIMEOUT (LOCK_TIMEOUT)
        ) u_aligner (
            .clk_pixel          (clk_pixel),
            .reset              (reset),
            .raw_i              (tmds_raw[g]),
`ifdef TMDS_WORD_ALIGNER_LOSS_COUNT_EN
            .clear_loss_count_i (clear_loss_count),
            .lock_loss_count_o  (lock_loss_count[g]),
`endif
            .aligned_o          (tmds_aligned[g]),
            .ctrl_token_o       (ctrl_token[g]),
            .locked_o           (locked[g]),
            .bit_offset_o       (bit_offset[g])
        );
    end

    // Register the AND of all lock bits so it trails them by one cycle.
    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= &locked;
        end
    end

    assign all_locked = all_locked_q;

endmodule : tmds_word_aligner
